debounce_edge: RTL and testbench

- Consumes the single-bit, active-low, idle-high output of the two-flop input synchronizer.
- Debounces that output and produces a clean level plus single-cycle press, release and long-hold pulses for downstream control logic.
- Also keeps a saturating count of rejected bounces for debug.
- Sits directly downstream of the synchronizer on every push-button/slow external input path.

---
 rtl/debounce_pkg.sv | 36 +++
 rtl/db_counter.sv | 53 +++++
 rtl/debounce_edge.sv | 209 ++++++++++++++++++++
 tb/tb_debounce_edge.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
//
// Shared definitions for the push-button debouncer (debounce_edge) and its
// counter sub-module (db_counter).
//
// Contents:
//   state_t            - debouncer FSM state encoding (2 bits)
//   DB_STABLE_CYCLES   - default acceptance window, in sampled cycles
//   DB_HOLD_CYCLES     - default long-press threshold, in cycles
//   DB_GLITCH_WIDTH    - default width of the rejected-bounce counter
//   STABLE_W / HOLD_W  - widths of the stable and hold counters
// -----------------------------------------------------------------------------
package debounce_pkg;

    // IDLE     : input stable high (released)
    // FALL_CHK : input went low, waiting to see if it stays low
    // ACTIVE   : input stable low (pressed)
    // RISE_CHK : input went high while pressed, waiting to see if it stays
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FALL_CHK = 2'd1,
        ACTIVE   = 2'd2,
        RISE_CHK = 2'd3
    } state_t;

    localparam int unsigned DB_STABLE_CYCLES = 16;
    localparam int unsigned DB_HOLD_CYCLES   = 2000;
    localparam int unsigned DB_GLITCH_WIDTH  = 8;

    // The stable counter must reach 255 (largest legal STABLE_CYCLES) and
    // the hold counter must reach 4095 (largest legal HOLD_CYCLES).
    localparam int unsigned STABLE_W = 8;
    localparam int unsigned HOLD_W   = 12;

endpackage : debounce_pkg

// File: rtl/db_counter.sv
// -----------------------------------------------------------------------------
// db_counter
//
// Parameterised saturating up-counter with synchronous clear.
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   synchronous active-high reset, forces count to 0
//   clear_i        in   restart the count from zero this cycle
//   count_en_i     in   advance the count by one this cycle
//   saturate_at_i  in   WIDTH  value at which counting stops
//   count_o        out  WIDTH  current count (registered)
//
// clear_i and count_en_i combine: the clear selects zero as the base value
// and the enable then adds one to that base. Asserting both together loads
// exactly 1, which is how the debouncer starts a candidate window on the
// very edge that first sees the new level.
// -----------------------------------------------------------------------------
module db_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             count_en_i,
    input  logic [WIDTH-1:0] saturate_at_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] base_d;

    always_comb begin
        base_d  = clear_i ? '0 : count_q;
        count_d = base_d;
        // Stop at the saturation value; never wrap.
        if (count_en_i && (base_d != saturate_at_i)) begin
            count_d = base_d + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule : db_counter

// File: rtl/debounce_edge.sv
// -----------------------------------------------------------------------------
// debounce_edge
//
// Debouncer for an active-low, idle-high, already-synchronised input. A new
// level is accepted only after it has been sampled on STABLE_CYCLES
// consecutive edges; any reversal inside that window aborts the candidate
// and is counted as a glitch.
//
// Parameters:
//   STABLE_CYCLES  consecutive samples needed to accept a level (2..255)
//   HOLD_CYCLES    cycles pressed before hold_pulse (> STABLE_CYCLES, <= 4095)
//   GLITCH_WIDTH   width of the saturating glitch counter
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   synchronous active-high reset
//   sync_in        in   synchronised input, 1 = released, 0 = pressed
//   debounced_out  out  debounced level, idle 1
//   fall_pulse     out  one-cycle strobe on accepted press
//   rise_pulse     out  one-cycle strobe on accepted release
//   hold_pulse     out  one-cycle strobe when a press has lasted HOLD_CYCLES
//   glitch_count   out  GLITCH_WIDTH  saturating count of aborted transitions
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module debounce_edge
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DB_STABLE_CYCLES,
    parameter int unsigned HOLD_CYCLES   = DB_HOLD_CYCLES,
    parameter int unsigned GLITCH_WIDTH  = DB_GLITCH_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sync_in,
    output logic                    debounced_out,
    output logic                    fall_pulse,
    output logic                    rise_pulse,
    output logic                    hold_pulse,
    output logic [GLITCH_WIDTH-1:0] glitch_count
);

    // "count + 1 == limit" is evaluated as "count == limit - 1" so the
    // compare stays at counter width with no carry bit.
    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(STABLE_CYCLES - 1);
    localparam logic [STABLE_W-1:0] STABLE_SAT  = STABLE_W'(STABLE_CYCLES);
    localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0]   HOLD_SAT    = HOLD_W'(HOLD_CYCLES);

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    state_t                  state_q,     state_d;
    logic                    debounced_q, debounced_d;
    logic                    fall_q,      fall_d;
    logic                    rise_q,      rise_d;
    logic                    hold_q,      hold_d;
    logic [GLITCH_WIDTH-1:0] glitch_q,    glitch_d;

    // Counter controls and values
    logic                    stable_clr;
    logic                    stable_en;
    logic [STABLE_W-1:0]     stable_cnt;
    logic                    hold_clr;
    logic                    hold_en;
    logic [HOLD_W-1:0]       hold_cnt;
    logic                    glitch_inc;

    // ------------------------------------------------------------------
    // Stable counter: consecutive samples of the candidate level
    // ------------------------------------------------------------------
    db_counter #(
        .WIDTH (STABLE_W)
    ) u_stable_cnt (
        .clk           (clk),
        .rst           (rst),
        .clear_i       (stable_clr),
        .count_en_i    (stable_en),
        .saturate_at_i (STABLE_SAT),
        .count_o       (stable_cnt)
    );

    // ------------------------------------------------------------------
    // Hold counter: cycles spent pressed. Runs only in ACTIVE, so a release
    // bounce (time spent in RISE_CHK) freezes it rather than restarting it.
    // ------------------------------------------------------------------
    db_counter #(
        .WIDTH (HOLD_W)
    ) u_hold_cnt (
        .clk           (clk),
        .rst           (rst),
        .clear_i       (hold_clr),
        .count_en_i    (hold_en),
        .saturate_at_i (HOLD_SAT),
        .count_o       (hold_cnt)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        debounced_d = debounced_q;
        fall_d      = 1'b0;
        rise_d      = 1'b0;
        hold_d      = 1'b0;
        glitch_inc  = 1'b0;
        stable_clr  = 1'b0;
        stable_en   = 1'b0;
        hold_clr    = 1'b0;
        hold_en     = 1'b0;

        case (state_q)
            IDLE: begin
                // Clear+enable loads 1: this edge is the first low sample.
                stable_clr = 1'b1;
                if (!sync_in) begin
                    stable_en = 1'b1;
                    state_d   = FALL_CHK;
                end
            end

            FALL_CHK: begin
                if (sync_in) begin
                    state_d    = IDLE;
                    stable_clr = 1'b1;
                    glitch_inc = 1'b1;
                end else if (stable_cnt == STABLE_LAST) begin
                    state_d     = ACTIVE;
                    debounced_d = 1'b0;
                    fall_d      = 1'b1;
                    stable_clr  = 1'b1;
                    hold_clr    = 1'b1;
                end else begin
                    stable_en = 1'b1;
                end
            end

            ACTIVE: begin
                // The hold counter advances on every ACTIVE edge, including
                // the one that moves to RISE_CHK. Saturation at HOLD_CYCLES
                // keeps the pulse condition from recurring in a long press.
                hold_en    = 1'b1;
                hold_d     = (hold_cnt == HOLD_LAST);
                stable_clr = 1'b1;
                if (sync_in) begin
                    stable_en = 1'b1;
                    state_d   = RISE_CHK;
                end
            end

            RISE_CHK: begin
                if (!sync_in) begin
                    state_d    = ACTIVE;
                    stable_clr = 1'b1;
                    glitch_inc = 1'b1;
                end else if (stable_cnt == STABLE_LAST) begin
                    state_d     = IDLE;
                    debounced_d = 1'b1;
                    rise_d      = 1'b1;
                    stable_clr  = 1'b1;
                    hold_clr    = 1'b1;
                end else begin
                    stable_en = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Glitch counter sticks at all-ones instead of wrapping.
    always_comb begin
        glitch_d = glitch_q;
        if (glitch_inc && (glitch_q != '1)) begin
            glitch_d = glitch_q + GLITCH_WIDTH'(1);
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            debounced_q <= 1'b1;
            fall_q      <= 1'b0;
            rise_q      <= 1'b0;
            hold_q      <= 1'b0;
            glitch_q    <= '0;
        end else begin
            state_q     <= state_d;
            debounced_q <= debounced_d;
            fall_q      <= fall_d;
            rise_q      <= rise_d;
            hold_q      <= hold_d;
            glitch_q    <= glitch_d;
        end
    end

    assign debounced_out = debounced_q;
    assign fall_pulse    = fall_q;
    assign rise_pulse    = rise_q;
    assign hold_pulse    = hold_q;
    assign glitch_count  = glitch_q;

endmodule : debounce_edge

// File: tb/tb_debounce_edge.sv
// -----------------------------------------------------------------------------
// tb_debounce_edge
//
// Directed bench for debounce_edge with STABLE_CYCLES=4, HOLD_CYCLES=20 and
// GLITCH_WIDTH=2. A vector table covers reset, clean press/release and
// bounced press/release; hand-written loops cover the long hold, the short
// press, glitch saturation and reset in the middle of a candidate press.
// Outputs are compared 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_debounce_edge;

    localparam int unsigned STABLE = 4;
    localparam int unsigned HOLD   = 20;
    localparam int unsigned GW     = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          sync_in;
    logic          debounced_out;
    logic          fall_pulse;
    logic          rise_pulse;
    logic          hold_pulse;
    logic [GW-1:0] glitch_count;

    int n_cmp = 0;
    int n_bad = 0;

    // exp packs {debounced_out, fall, rise, hold, glitch_count[1:0]}
    typedef struct {
        logic       rst;
        logic       sin;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl[$];

    debounce_edge #(
        .STABLE_CYCLES (STABLE),
        .HOLD_CYCLES   (HOLD),
        .GLITCH_WIDTH  (GW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sync_in       (sync_in),
        .debounced_out (debounced_out),
        .fall_pulse    (fall_pulse),
        .rise_pulse    (rise_pulse),
        .hold_pulse    (hold_pulse),
        .glitch_count  (glitch_count)
    );

    always #5 clk = ~clk;

    task automatic add(input int n, input logic r, input logic s,
                       input logic db, input logic f, input logic rr,
                       input logic h, input logic [1:0] g);
        vec_t e;
        e.rst = r;
        e.sin = s;
        e.exp = {db, f, rr, h, g};
        for (int i = 0; i < n; i++) tbl.push_back(e);
    endtask

    // Drive inputs, take one rising edge, settle just past it.
    task automatic step(input logic r, input logic s);
        rst     = r;
        sync_in = s;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int idx, input logic [5:0] exp);
        logic [5:0] act;
        act = {debounced_out, fall_pulse, rise_pulse, hold_pulse, glitch_count};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got db/fall/rise/hold/glitch=%b/%b/%b/%b/%0d expected %b/%b/%b/%b/%0d",
                     tag, idx, act[5], act[4], act[3], act[2], act[1:0],
                     exp[5], exp[4], exp[3], exp[2], exp[1:0]);
        end else begin
            $display("ok   %s[%0d]: db/fall/rise/hold/glitch=%b/%b/%b/%b/%0d",
                     tag, idx, act[5], act[4], act[3], act[2], act[1:0]);
        end
    endtask

    function automatic logic [1:0] sat3(input int k);
        return (k > 3) ? 2'd3 : 2'(k);
    endfunction

    initial begin
        logic       s;
        logic [5:0] exp;

        rst     = 1'b1;
        sync_in = 1'b1;

        // ---------------- vector table ----------------
        //    n  rst sin  db f  r  h  glitch
        // Reset held with input low, then press accepted on 4th edge.
        add(3, 1, 0,   1, 0, 0, 0, 2'd0);
        add(3, 0, 0,   1, 0, 0, 0, 2'd0);
        add(1, 0, 0,   0, 1, 0, 0, 2'd0);
        add(1, 0, 0,   0, 0, 0, 0, 2'd0);
        // Clean release.
        add(3, 0, 1,   0, 0, 0, 0, 2'd0);
        add(1, 0, 1,   1, 0, 1, 0, 2'd0);
        add(1, 0, 1,   1, 0, 0, 0, 2'd0);
        // Clean press held 10 cycles.
        add(3, 0, 0,   1, 0, 0, 0, 2'd0);
        add(1, 0, 0,   0, 1, 0, 0, 2'd0);
        add(6, 0, 0,   0, 0, 0, 0, 2'd0);
        add(3, 0, 1,   0, 0, 0, 0, 2'd0);
        add(1, 0, 1,   1, 0, 1, 0, 2'd0);
        // Reset, then press bounce 0,0,1,0,0,0,0.
        add(1, 1, 1,   1, 0, 0, 0, 2'd0);
        add(2, 0, 0,   1, 0, 0, 0, 2'd0);
        add(1, 0, 1,   1, 0, 0, 0, 2'd1);
        add(3, 0, 0,   1, 0, 0, 0, 2'd1);
        add(1, 0, 0,   0, 1, 0, 0, 2'd1);
        add(1, 0, 0,   0, 0, 0, 0, 2'd1);
        // Release with bounce 1,0,1,1,1,1.
        add(1, 0, 1,   0, 0, 0, 0, 2'd1);
        add(1, 0, 0,   0, 0, 0, 0, 2'd2);
        add(3, 0, 1,   0, 0, 0, 0, 2'd2);
        add(1, 0, 1,   1, 0, 1, 0, 2'd2);
        add(1, 0, 1,   1, 0, 0, 0, 2'd2);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].sin);
            check("vec", i, tbl[i].exp);
        end

        // ---------------- long hold with release bounce ----------------
        step(1'b1, 1'b1);
        check("t5_rst", 0, 6'b100000);
        for (int e = 1; e <= 4; e++) begin
            step(1'b0, 1'b0);
            exp = {(e < 4), (e == 4), 1'b0, 1'b0, 2'd0};
            check("t5_press", e, exp);
        end
        // e counts edges after the fall_pulse edge. Bounce high at 10,11;
        // released for good from 31.
        for (int e = 1; e <= 36; e++) begin
            s = (e == 10) || (e == 11) || (e > 30);
            step(1'b0, s);
            exp = {(e >= 34), 1'b0, (e == 34), (e == 22), (e >= 12) ? 2'd1 : 2'd0};
            check("t5_hold", e, exp);
        end

        // ---------------- short 15-cycle press: no hold ----------------
        for (int e = 1; e <= 20; e++) begin
            s = (e > 15);
            step(1'b0, s);
            exp = {!((e >= 4) && (e < 19)), (e == 4), (e == 19), 1'b0, 2'd1};
            check("t5_short", e, exp);
        end

        // ---------------- glitch saturation ----------------
        step(1'b1, 1'b1);
        check("t6_rst", 0, 6'b100000);
        for (int k = 1; k <= 5; k++) begin
            step(1'b0, 1'b0);
            exp = {1'b1, 1'b0, 1'b0, 1'b0, sat3(k - 1)};
            check("t6_cand", k, exp);
            step(1'b0, 1'b1);
            exp = {1'b1, 1'b0, 1'b0, 1'b0, sat3(k)};
            check("t6_abort", k, exp);
        end
        // Enter FALL_CHK, then reset mid-candidate with input still low.
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("t6_mid", 0, 6'b100011);
        step(1'b1, 1'b0);
        check("t6_midrst", 0, 6'b100000);
        // Must restart from IDLE: fall exactly on the 4th edge after release.
        for (int e = 1; e <= 4; e++) begin
            step(1'b0, 1'b0);
            exp = {(e < 4), (e == 4), 1'b0, 1'b0, 2'd0};
            check("t6_after", e, exp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_debounce_edge
